imem_loader: RTL and testbench

Byte-serial program loader for the single-cycle RISC-V core. It holds the core in reset, receives a program as a little-endian byte stream over a valid/ready handshake, and packs the bytes into 32-bit words. Each word is written into instruction memory at consecutive word addresses starting at 0, and the core is released when the last word is written. It drives the core's `reset` pin in the top-level test and bring-up harness, replacing a fixed reset pulse.

---
 rtl/rv_pkg.sv | 13 +
 rtl/imem_loader_byte_packer.sv | 41 ++++
 rtl/imem_loader.sv | 130 +++++++++++++
 tb/tb_imem_loader.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared definitions for the core bring-up slice: word width and loader states.
package rv_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    RUN   = 2'd3
  } loader_state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words. The byte index wraps
// after byte 3, so every word starts from a freshly overwritten lane set.
module byte_packer
  import rv_pkg::*;
(
  input  logic             clk,
  input  logic             accept,
  input  logic [7:0]       byte_in,
  input  logic             clear,
  output logic             word_full,
  output logic [WIDTH-1:0] word_out
);

  logic [1:0]       idx_p0;
  logic [WIDTH-1:0] pack_p0;

  // Byte lane index; clear discards any partially packed word.
  always_ff @(posedge clk) begin
    if (clear) begin
      idx_p0 <= 2'd0;
    end else if (accept) begin
      idx_p0 <= idx_p0 + 2'd1;
    end
  end

  // Pack register; each lane is always overwritten before it is used.
  always_ff @(posedge clk) begin
    if (accept) begin
      pack_p0[{idx_p0, 3'b000} +: 8] <= byte_in;
    end
  end

  // Completed word includes the byte arriving on the closing transfer.
  always_comb begin
    word_out                        = pack_p0;
    word_out[{idx_p0, 3'b000} +: 8] = byte_in;
  end

  assign word_full = accept && (idx_p0 == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Program loader: holds the core in reset, streams bytes into instruction
// memory word by word, then releases the core once the last word lands.
module imem_loader
  import rv_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WIDTH-1:0]  imem_wdata,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  checksum
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  loader_state_t     state, state_nxt;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W-1:0] widx;
  logic              start_acc;
  logic              accept;
  logic              last_word;
  logic              word_full;
  logic [WIDTH-1:0]  word_out;
  logic              pack_clear;

  // Requests larger than the memory are cut to the memory size.
  function automatic logic [ADDR_W:0] clamp_count(input logic [ADDR_W:0] c);
    if (c > DEPTH_C) begin
      return DEPTH_C;
    end
    return c;
  endfunction

  assign start_acc  = start && (word_count != '0) && ((state == IDLE) || (state == RUN));
  assign accept     = byte_valid && byte_ready;
  assign last_word  = ({1'b0, widx} == (count_q - 1'b1));
  assign pack_clear = reset || start_acc;

  byte_packer u_packer (
    .clk       (clk),
    .accept    (accept),
    .byte_in   (byte_data),
    .clear     (pack_clear),
    .word_full (word_full),
    .word_out  (word_out)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: WRITE is always a single cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_acc) state_nxt = LOAD;
      LOAD:    if (word_full) state_nxt = WRITE;
      WRITE:   state_nxt = last_word ? RUN : LOAD;
      RUN:     if (start_acc) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  // Control outputs decode only the state flop, never the inputs.
  always_comb begin
    byte_ready = 1'b0;
    imem_we    = 1'b0;
    core_reset = 1'b1;
    busy       = 1'b0;
    case (state)
      LOAD: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
      end
      WRITE: begin
        imem_we = 1'b1;
        busy    = 1'b1;
      end
      RUN:     core_reset = 1'b0;
      default: ;
    endcase
  end

  // Count, word index, write port registers, checksum and done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      widx       <= '0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      checksum   <= '0;
      done       <= 1'b0;
    end else begin
      done <= (state == WRITE) && last_word;
      if (start_acc) begin
        count_q  <= clamp_count(word_count);
        widx     <= '0;
        checksum <= '0;
      end
      // Write port is loaded on entry to WRITE and holds afterwards.
      if (word_full) begin
        imem_addr  <= widx;
        imem_wdata <= word_out;
      end
      if (state == WRITE) begin
        checksum <= checksum ^ imem_wdata;
        if (!last_word) begin
          widx <= widx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as bytes are
// driven and popped when the loader strobes instruction memory.
module tb_imem_loader;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W:0]   word_count = '0;
  logic              byte_valid = 1'b0;
  logic [7:0]        byte_data = '0;
  logic              byte_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_reset;
  logic              busy;
  logic              done;
  logic [31:0]       checksum;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .word_count (word_count),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_reset (core_reset),
    .busy       (busy),
    .done       (done),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } wr_t;

  wr_t         sbq[$];
  int          n_vec = 0;
  int          n_miss = 0;
  int          cyc = 0;
  int          we_cyc = -10;
  int          n_we = 0;
  int          n_done = 0;
  logic        prev_done = 1'b0;
  logic [31:0] prog[DEPTH];
  logic [31:0] exp_ck;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Write and done monitor.
  always @(negedge clk) begin
    wr_t e;
    if (!reset) begin
      if (imem_we) begin
        n_we++;
        we_cyc = cyc;
        if (sbq.size() == 0) begin
          chk("unexpected_we", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("we_addr", 32'(imem_addr), 32'(e.a));
          chk("we_data", imem_wdata, e.d);
        end
        chk("ready_in_write", 32'(byte_ready), 32'd0);
      end
      if (done) begin
        n_done++;
        chk("done_latency", 32'(cyc), 32'(we_cyc + 1));
        chk("done_core_reset", 32'(core_reset), 32'd0);
      end
      if (prev_done) chk("done_width", 32'(done), 32'd0);
    end
    prev_done = done;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int cnt);
    start      = 1'b1;
    word_count = (ADDR_W + 1)'(cnt);
    tick();
    start = 1'b0;
    #2;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("core_reset_load", 32'(core_reset), 32'd1);
  endtask

  // Present one byte, optionally after idle cycles, and wait for the transfer.
  task automatic send_byte(input logic [7:0] b, input int stall, input bit poke);
    int t;
    byte_valid = 1'b0;
    repeat (stall) tick();
    byte_valid = 1'b1;
    byte_data  = b;
    if (poke) begin
      start      = 1'b1;
      word_count = 7'd3;
    end
    t = 0;
    @(negedge clk);
    while (!byte_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!byte_ready) chk("handshake_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    start      = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int t;
    t = 0;
    while (!done && t < lim) begin
      @(negedge clk);
      t++;
    end
    if (!done) begin
      chk("done_timeout", 32'd0, 32'd1);
    end else begin
      chk("checksum", checksum, exp_ck);
      chk("core_reset_run", 32'(core_reset), 32'd0);
      chk("busy_run", 32'(busy), 32'd0);
    end
    tick();
  endtask

  // Queue the expected writes, start the load and stream n words of prog.
  task automatic load_prog(input int n, input int cnt, input int stall_mode, input bit poke);
    int nw;
    wr_t e;
    nw = (cnt > DEPTH) ? DEPTH : cnt;
    exp_ck = '0;
    for (int w = 0; w < nw; w++) begin
      e.a = ADDR_W'(w);
      e.d = prog[w];
      sbq.push_back(e);
      exp_ck ^= prog[w];
    end
    do_start(cnt);
    for (int w = 0; w < n; w++) begin
      for (int k = 0; k < 4; k++) begin
        send_byte(prog[w][8*k +: 8], (stall_mode == 1) ? (k % 2) : 0, poke && (w == 0) && (k == 1));
      end
    end
    wait_done(200);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, "_we"}, 32'(imem_we), 32'd0);
    chk({tag, "_addr"}, 32'(imem_addr), 32'd0);
    chk({tag, "_wdata"}, imem_wdata, 32'd0);
    chk({tag, "_core_reset"}, 32'(core_reset), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_checksum"}, checksum, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int we0;
    // Reset state.
    repeat (3) tick();
    @(negedge clk);
    check_reset_values("rst");
    reset = 1'b0;
    tick();

    // Single word, no stalls.
    prog[0] = 32'hDEADBEEF;
    load_prog(1, 1, 0, 1'b0);

    // Two words under byte_valid toggling.
    prog[0] = 32'h12345678;
    prog[1] = 32'hCAFEF00D;
    load_prog(2, 2, 1, 1'b0);

    // Reset after two bytes of word 0; stale bytes must not surface.
    do_start(1);
    send_byte(8'hAA, 0, 1'b0);
    send_byte(8'hBB, 0, 1'b0);
    reset = 1'b1;
    tick();
    @(negedge clk);
    check_reset_values("midrst");
    reset = 1'b0;
    tick();
    prog[0] = 32'h00000013;
    load_prog(1, 1, 0, 1'b0);

    // Start during LOAD is ignored; zero-count start in RUN is ignored.
    for (int i = 0; i < 5; i++) prog[i] = $urandom;
    load_prog(5, 5, 0, 1'b1);
    start      = 1'b1;
    word_count = '0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("run_core_reset", 32'(core_reset), 32'd0);
      chk("run_busy", 32'(busy), 32'd0);
    end
    tick();

    // Oversized count clamps to the memory depth.
    for (int i = 0; i < DEPTH; i++) prog[i] = $urandom;
    we0 = n_we;
    load_prog(DEPTH, 127, 0, 1'b0);
    repeat (5) tick();
    chk("clamp_writes", 32'(n_we - we0), 32'd64);
    chk("clamp_run", 32'(core_reset), 32'd0);
    chk("done_pulses", 32'(n_done), 32'd5);
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
